// File: rtl/demux1to2_capture.sv
// rtl/demux1to2_capture.sv - registered 1-to-2 nibble demultiplexer with pair-ready/ack handshake
// Two valid bits form the fill state; the data slots and the sticky drop flag ride alongside it.
module demux1to2_capture #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    input  logic             select_mode,
    input  logic             select,
    input  logic             clear,
    input  logic             pair_ack,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic             out1_valid,
    output logic             out2_valid,
    output logic             pair_ready,
    output logic             dropped
);

    // Fill state: bit 0 = slot 1 valid, bit 1 = slot 2 valid.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_FULL  = 2'b11;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] out1_q, out1_d;
    logic [WIDTH-1:0] out2_q, out2_d;
    logic             dropped_q, dropped_d;
    logic             to_slot2;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_EMPTY;
            out1_q    <= '0;
            out2_q    <= '0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            out1_q    <= out1_d;
            out2_q    <= out2_d;
            dropped_q <= dropped_d;
        end
    end

    // Auto mode fills slot 1 first whenever it is free, even if slot 2 already holds data.
    assign to_slot2 = select_mode ? state_q[0] : select;

    always_comb begin
        state_d   = state_q;
        out1_d    = out1_q;
        out2_d    = out2_q;
        dropped_d = dropped_q;
        if (clear) begin
            state_d   = ST_EMPTY;
            out1_d    = '0;
            out2_d    = '0;
            dropped_d = 1'b0;
        end else if (pair_ack && (state_q == ST_FULL)) begin
            // Data is retained for display; only the handshake state is released.
            state_d = ST_EMPTY;
        end else if (load) begin
            if (state_q == ST_FULL) begin
                dropped_d = 1'b1;
            end else if (to_slot2) begin
                out2_d     = data_in;
                state_d[1] = 1'b1;
            end else begin
                out1_d     = data_in;
                state_d[0] = 1'b1;
            end
        end
    end

    always_comb begin
        out1       = out1_q;
        out2       = out2_q;
        out1_valid = state_q[0];
        out2_valid = state_q[1];
        pair_ready = (state_q == ST_FULL);
        dropped    = dropped_q;
    end

endmodule

// File: tb/tb_demux1to2_capture.sv
// tb/tb_demux1to2_capture.sv - scoreboard bench for demux1to2_capture
// Expected snapshot per edge: {out1, out2, out1_valid, out2_valid, pair_ready, dropped}.
module tb_demux1to2_capture;

    logic       clk;
    logic       rst;
    logic [3:0] data_in;
    logic       load;
    logic       select_mode;
    logic       select;
    logic       clear;
    logic       pair_ack;
    logic [3:0] out1;
    logic [3:0] out2;
    logic       out1_valid;
    logic       out2_valid;
    logic       pair_ready;
    logic       dropped;

    logic [11:0] exp_q[$];
    int          total = 0;
    int          bad   = 0;

    demux1to2_capture #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .load        (load),
        .select_mode (select_mode),
        .select      (select),
        .clear       (clear),
        .pair_ack    (pair_ack),
        .out1        (out1),
        .out2        (out2),
        .out1_valid  (out1_valid),
        .out2_valid  (out2_valid),
        .pair_ready  (pair_ready),
        .dropped     (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        logic [11:0] e;
        logic [11:0] act;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {out1, out2, out1_valid, out2_valid, pair_ready, dropped};
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL snap#%0d: got o1=%h o2=%h v=%b%b pr=%b dr=%b, want o1=%h o2=%h v=%b%b pr=%b dr=%b",
                         total, act[11:8], act[7:4], act[3], act[2], act[1], act[0],
                         e[11:8], e[7:4], e[3], e[2], e[1], e[0]);
            end
        end
    end

    task automatic step(input logic r, input logic c, input logic a, input logic l,
                        input logic m, input logic s, input logic [3:0] d,
                        input logic [11:0] e);
        @(negedge clk);
        rst = r; clear = c; pair_ack = a; load = l;
        select_mode = m; select = s; data_in = d;
        @(posedge clk);
        #1 exp_q.push_back(e);
    endtask

    initial begin
        rst = 1'b0; clear = 1'b0; pair_ack = 1'b0; load = 1'b0;
        select_mode = 1'b0; select = 1'b0; data_in = 4'h0;

        //     rst clr ack ld mode sel data   o1    o2   v1 v2 pr dr
        step(0, 0, 0, 1, 1, 0, 4'hF, {4'h0, 4'h0, 4'b0000});
        step(0, 0, 0, 1, 1, 0, 4'hF, {4'h0, 4'h0, 4'b0000});
        step(1, 0, 0, 0, 1, 0, 4'h0, {4'h0, 4'h0, 4'b0000});
        // auto fill 3 then A
        step(1, 0, 0, 1, 1, 0, 4'h3, {4'h3, 4'h0, 4'b1000});
        step(1, 0, 0, 1, 1, 0, 4'hA, {4'h3, 4'hA, 4'b1110});
        step(1, 0, 0, 0, 1, 0, 4'h0, {4'h3, 4'hA, 4'b1110});
        step(1, 0, 1, 0, 1, 0, 4'h0, {4'h3, 4'hA, 4'b0000});
        // overflow from FULL 5/6
        step(1, 0, 0, 1, 1, 0, 4'h5, {4'h5, 4'hA, 4'b1000});
        step(1, 0, 0, 1, 1, 0, 4'h6, {4'h5, 4'h6, 4'b1110});
        step(1, 0, 0, 1, 1, 0, 4'h9, {4'h5, 4'h6, 4'b1111});
        step(1, 0, 1, 0, 1, 0, 4'h0, {4'h5, 4'h6, 4'b0001});
        step(1, 0, 0, 0, 1, 0, 4'h0, {4'h5, 4'h6, 4'b0001});
        step(1, 1, 0, 0, 1, 0, 4'h0, {4'h0, 4'h0, 4'b0000});
        // explicit steering with overwrite
        step(1, 0, 0, 1, 0, 1, 4'h7, {4'h0, 4'h7, 4'b0100});
        step(1, 0, 0, 1, 0, 1, 4'h2, {4'h0, 4'h2, 4'b0100});
        step(1, 0, 0, 1, 0, 0, 4'h4, {4'h4, 4'h2, 4'b1110});
        // drop while full, then ack+load together keeps dropped and data
        step(1, 0, 0, 1, 0, 1, 4'hB, {4'h4, 4'h2, 4'b1111});
        step(1, 0, 1, 1, 1, 0, 4'hC, {4'h4, 4'h2, 4'b0001});
        // ack when not full is ignored; load in same cycle proceeds
        step(1, 0, 1, 1, 1, 0, 4'hD, {4'hD, 4'h2, 4'b1001});
        step(1, 0, 1, 0, 1, 0, 4'h0, {4'hD, 4'h2, 4'b1001});
        // explicit overwrite of valid slot 1
        step(1, 0, 0, 1, 0, 0, 4'h6, {4'h6, 4'h2, 4'b1001});
        // flush mid-fill
        step(1, 1, 0, 0, 1, 0, 4'h0, {4'h0, 4'h0, 4'b0000});
        step(1, 0, 0, 1, 1, 0, 4'h1, {4'h1, 4'h0, 4'b1000});
        step(1, 1, 0, 1, 1, 0, 4'hE, {4'h0, 4'h0, 4'b0000});
        step(1, 0, 0, 1, 1, 0, 4'h8, {4'h8, 4'h0, 4'b1000});
        // reset mid-fill, then auto load lands in slot 1
        step(0, 0, 0, 0, 1, 0, 4'h0, {4'h0, 4'h0, 4'b0000});
        step(1, 0, 0, 1, 1, 0, 4'h8, {4'h8, 4'h0, 4'b1000});
        // auto mode with only slot 2 valid picks slot 1
        step(1, 1, 0, 0, 1, 0, 4'h0, {4'h0, 4'h0, 4'b0000});
        step(1, 0, 0, 1, 0, 1, 4'h9, {4'h0, 4'h9, 4'b0100});
        step(1, 0, 0, 1, 1, 1, 4'h3, {4'h3, 4'h9, 4'b1110});

        @(negedge clk);
        rst = 1'b1; clear = 1'b0; pair_ack = 1'b0; load = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d snapshots unchecked, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux1to2_capture.md
# demux1to2_capture

Registered 1-to-2 demultiplexer that steers a stream of 4-bit nibbles into two holding registers. It is the write-side counterpart of the 2-to-1 selector in the face-building datapath. Switch-entered nibbles arrive with a one-cycle `load` pulse. Each nibble is captured into slot 1 or slot 2, either by an explicit select or by automatic alternation. A pair-ready/acknowledge handshake hands the completed pair to the downstream consumer.

## Interface
- `WIDTH`, default 4, data width of the input and of each slot.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-low reset.
- `data_in`  input  WIDTH  nibble to capture.
- `load`  input  1  single-cycle capture strobe from the upstream one-shot.
- `select_mode`  input  1  0 = explicit steering by `select`; 1 = auto alternation.
- `select`  input  1  explicit target: 0 = slot 1, 1 = slot 2. Ignored when `select_mode`=1.
- `clear`  input  1  synchronous flush of both slots and all flags.
- `pair_ack`  input  1  consumer has taken the pair.
- `out1`, `out2`  output  WIDTH  slot 1 and slot 2 contents (registered).
- `out1_valid`, `out2_valid`  output  1  slot holds an unconsumed nibble.
- `pair_ready`  output  1  `out1_valid & out2_valid`.
- `dropped`  output  1  sticky flag: a load was discarded while the block was full.

## Operation
- State is encoded by the two valid bits:
  - EMPTY (00)
  - PARTIAL (10 or 01)
  - FULL (11)
- Priority each cycle, highest first: `rst` low, then `clear`, then `pair_ack`, then `load`.
- Reset (`rst`=0): `out1`, `out2` = 0; both valids = 0; `dropped` = 0.
- `clear`=1: same effect as reset. Any `load` or `pair_ack` in that cycle is ignored.
- Load target:
  - Explicit mode: target is `select`.
  - Auto mode: target is slot 1 if `out1_valid`=0, otherwise slot 2.
  - Both modes are evaluated only at the `load` edge. Changing `select_mode` between loads is legal and takes effect on the next load.
- `load`=1 when not FULL: write `data_in` to the target slot and set its valid bit.
- Explicit-mode load into a slot that is already valid (PARTIAL state): overwrite the data; the valid stays 1.
- `load`=1 in FULL: no write, slot contents unchanged, `dropped` set to 1.
- `pair_ack`=1 in FULL:
  - Both valids cleared; `out1`/`out2` keep their data.
  - A `load` in the same cycle is ignored and does not set `dropped`.
- `pair_ack`=1 when not FULL: no effect.
- `dropped` clears only on reset or `clear`.
- No arithmetic is performed; data is passed through unmodified at full WIDTH.

## Timing
- Capture latency is 1 cycle: `load` sampled at edge k, so `outN`/`outN_valid` update after edge k.
- `pair_ready` is derived combinationally from the registered valids. It rises in the cycle after the second capture edge.
- `pair_ack` sampled at edge k drops `pair_ready` after edge k. A new load is accepted from edge k+1.
- A load held high for multiple cycles counts as one load per cycle. Upstream guarantees single-cycle pulses.
- Reset or clear asserted mid-fill (PARTIAL) discards the partial pair. The next auto-mode load goes to slot 1.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with `load`=1 and `data_in`=4'hF. Required: all outputs 0; `dropped`=0.
- Auto fill: `select_mode`=1; load 4'h3, then 4'hA on consecutive cycles. Required:
  - `out1`=3, `out2`=A.
  - `pair_ready` is 1 one cycle after the second load.
  - Then `pair_ack` clears both valids; `out1`/`out2` still read 3/A.
- Overflow: from FULL (5/6), load 4'h9. Required: `out1`/`out2` remain 5/6; `dropped`=1, and it stays 1 after `pair_ack`. Only `clear` returns it to 0.
- Explicit steering with overwrite:
  - `select_mode`=0; load 4'h7 with `select`=1, then 4'h2 with `select`=1. Required: `out2`=2; `out1_valid`=0; `pair_ready`=0.
  - Then load 4'h4 with `select`=0. Required: `pair_ready`=1.
- Simultaneous events in FULL: `pair_ack`=1 and `load`=1 with 4'hC in the same cycle. Required: valids become 0; `out1`/`out2` unchanged; `dropped` unchanged.
- Flush mid-fill: auto mode, load 4'h1, then `clear` together with `load` of 4'hE. Required: all outputs 0. The next load of 4'h8 lands in `out1`.
